irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_irq_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: 16-source prioritised interrupt controller with a byte-wide register port.
// Optional NMI input is compiled in when IRQ_CONTROLLER_NMI_EN is defined.

module irq_lane (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic prev_q, prev_d;
  logic pend_q, pend_d;

  // A rise on the same edge as a clear wins, so no event is ever lost
  always_comb begin
    prev_d = src;
    pend_d = (src & ~prev_q) | (pend_q & ~clr);
  end

  // prev keeps sampling through reset: a source held high across reset never latches
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign pend = pend_q;
endmodule

module irq_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] irq_src,
  input  logic        iack,
`ifdef IRQ_CONTROLLER_NMI_EN
  input  logic        nmi,
`endif
  input  logic [3:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_write,
  input  logic        reg_read,
  output logic [7:0]  reg_rdata,
  output logic [1:0]  cpu_irq_level,
  output logic [7:0]  cpu_vector
);
  localparam int NUM_SRC = 16;

  typedef enum logic [1:0] {IDLE, REQUEST, ACK} state_e;

  state_e                  state_q, state_d;
  logic [NUM_SRC-1:0]      enable_q, enable_d;
  logic [NUM_SRC-1:0][1:0] prio_q, prio_d;
  logic [3:0]              stat_idx_q, stat_idx_d;
  logic [3:0]              cur_idx_q, cur_idx_d;
  logic                    cur_nmi_q, cur_nmi_d;
  logic [1:0]              level_q, level_d;
  logic [7:0]              vector_q, vector_d;
  logic [7:0]              rdata_q, rdata_d;

  logic [NUM_SRC-1:0] pending, w1c, ack_clr, cand;
  logic               ack_now, any_req, nmi_pend;
  logic [1:0]         win_prio, pres_level;
  logic [3:0]         win_idx;
  logic [7:0]         pres_vector, prio_byte;

  assign ack_now = (state_q == REQUEST) && iack;
  assign ack_clr = (ack_now && !cur_nmi_q) ? (16'd1 << cur_idx_q) : 16'd0;

  always_comb begin
    w1c = '0;
    if (reg_write && reg_addr == 4'h2) w1c[7:0]  = reg_wdata;
    if (reg_write && reg_addr == 4'h3) w1c[15:8] = reg_wdata;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    irq_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .src   (irq_src[i]),
      .clr   (w1c[i] | ack_clr[i]),
      .pend  (pending[i])
    );
  end

`ifdef IRQ_CONTROLLER_NMI_EN
  logic nmi_prev_q, nmi_pend_q, nmi_pend_d, nmi_ack;

  assign nmi_ack = ack_now & cur_nmi_q;

  always_comb nmi_pend_d = (nmi & ~nmi_prev_q) | (nmi_pend_q & ~nmi_ack);

  always_ff @(posedge clk) begin
    nmi_prev_q <= nmi;
    if (reset) nmi_pend_q <= 1'b0;
    else       nmi_pend_q <= nmi_pend_d;
  end

  assign nmi_pend = nmi_pend_q;
`else
  assign nmi_pend = 1'b0;
`endif

  // Strict '>' scanning upward keeps the lowest index on equal priority
  always_comb begin
    cand     = pending & enable_q;
    win_prio = 2'd0;
    win_idx  = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (prio_q[i] == 2'd0) cand[i] = 1'b0;
      if (cand[i] && prio_q[i] > win_prio) begin
        win_prio = prio_q[i];
        win_idx  = 4'(i);
      end
    end
    any_req     = (|cand) | nmi_pend;
    pres_level  = nmi_pend ? 2'd3 : win_prio;
    pres_vector = nmi_pend ? 8'h04 : 8'h10 + {3'b000, win_idx, 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    vector_d   = vector_q;
    cur_idx_d  = cur_idx_q;
    cur_nmi_d  = cur_nmi_q;
    stat_idx_d = stat_idx_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = REQUEST;
          level_d   = pres_level;
          vector_d  = pres_vector;
          cur_idx_d = win_idx;
          cur_nmi_d = nmi_pend;
        end
      end
      REQUEST: begin
        // An acknowledge takes precedence: the CPU has already consumed the vector
        if (iack) begin
          state_d    = ACK;
          level_d    = 2'd0;
          stat_idx_d = cur_nmi_q ? 4'hF : cur_idx_q;
        end else if (!any_req) begin
          state_d = IDLE;
          level_d = 2'd0;
        end else begin
          level_d   = pres_level;
          vector_d  = pres_vector;
          cur_idx_d = win_idx;
          cur_nmi_d = nmi_pend;
        end
      end
      ACK: begin
        state_d = IDLE;
        level_d = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enable_d = enable_q;
    prio_d   = prio_q;
    if (reg_write) begin
      case (reg_addr)
        4'h0: enable_d[7:0]  = reg_wdata;
        4'h1: enable_d[15:8] = reg_wdata;
        4'h4, 4'h5, 4'h6, 4'h7: begin
          for (int j = 0; j < 4; j++)
            prio_d[{reg_addr[1:0], 2'(j)}] = reg_wdata[2*j +: 2];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prio_byte = '0;
    for (int j = 0; j < 4; j++)
      prio_byte[2*j +: 2] = prio_q[{reg_addr[1:0], 2'(j)}];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (reg_read) begin
      case (reg_addr)
        4'h0:                   rdata_d = enable_q[7:0];
        4'h1:                   rdata_d = enable_q[15:8];
        4'h2:                   rdata_d = pending[7:0];
        4'h3:                   rdata_d = pending[15:8];
        4'h4, 4'h5, 4'h6, 4'h7: rdata_d = prio_byte;
        4'h8:                   rdata_d = {state_q == ACK, 3'b000, stat_idx_q};
        default:                rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      enable_q   <= '0;
      prio_q     <= '0;
      stat_idx_q <= 4'd0;
      cur_idx_q  <= 4'd0;
      cur_nmi_q  <= 1'b0;
      level_q    <= 2'd0;
      vector_q   <= 8'h00;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      prio_q     <= prio_d;
      stat_idx_q <= stat_idx_d;
      cur_idx_q  <= cur_idx_d;
      cur_nmi_q  <= cur_nmi_d;
      level_q    <= level_d;
      vector_q   <= vector_d;
      rdata_q    <= rdata_d;
    end
  end

  assign reg_rdata     = rdata_q;
  assign cpu_irq_level = level_q;
  assign cpu_vector    = vector_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic, all checked
// against a behavioural model of the register map and request/acknowledge protocol.
module tb_irq_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irq_src;
  logic        iack, nmi_in;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_write, reg_read;
  logic [7:0]  reg_rdata;
  logic [1:0]  cpu_irq_level;
  logic [7:0]  cpu_vector;

  int n_cmp = 0;
  int n_err = 0;

  irq_controller dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .iack          (iack),
`ifdef IRQ_CONTROLLER_NMI_EN
    .nmi           (nmi_in),
`endif
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_write     (reg_write),
    .reg_read      (reg_read),
    .reg_rdata     (reg_rdata),
    .cpu_irq_level (cpu_irq_level),
    .cpu_vector    (cpu_vector)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = nothing shown, 1 = request shown, 2 = acknowledged
  bit [15:0] m_en, m_pend, m_prev;
  int        m_pr[16];
  bit        m_npend, m_nprev;
  int        m_phase, m_lvl, m_vec, m_cur, m_stat, m_rdata;

  function automatic int m_read(int a);
    int v;
    v = 0;
    case (a)
      0: v = int'(m_en[7:0]);
      1: v = int'(m_en[15:8]);
      2: v = int'(m_pend[7:0]);
      3: v = int'(m_pend[15:8]);
      4, 5, 6, 7: for (int j = 0; j < 4; j++) v += m_pr[(a - 4) * 4 + j] << (2 * j);
      8: v = (m_phase == 2 ? 128 : 0) + m_stat;
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_present(int b);
    m_cur = b;
    m_lvl = (b == 16) ? 3 : m_pr[b];
    m_vec = (b == 16) ? 4 : 16 + 2 * b;
  endtask

  task automatic m_step();
    int best;
    bit [15:0] clr;
    bit nclr;
    if (reset) begin
      m_prev = irq_src; m_nprev = nmi_in;
      m_en = '0; m_pend = '0; m_npend = 0;
      for (int i = 0; i < 16; i++) m_pr[i] = 0;
      m_phase = 0; m_lvl = 0; m_vec = 0; m_cur = 0; m_stat = 0; m_rdata = 0;
      return;
    end
    if (reg_read) m_rdata = m_read(int'(reg_addr));
    best = -1;
    for (int i = 0; i < 16; i++)
      if (m_pend[i] && m_en[i] && m_pr[i] != 0 && (best < 0 || m_pr[i] > m_pr[best])) best = i;
    if (m_npend) best = 16;
    clr = '0; nclr = 0;
    case (m_phase)
      0: if (best >= 0) begin m_phase = 1; m_present(best); end
      1: begin
        if (iack) begin
          if (m_cur == 16) nclr = 1; else clr[m_cur] = 1'b1;
          m_stat = (m_cur == 16) ? 15 : m_cur;
          m_phase = 2; m_lvl = 0;
        end else if (best < 0) begin
          m_phase = 0; m_lvl = 0;
        end else m_present(best);
      end
      default: begin m_phase = 0; m_lvl = 0; end
    endcase
    if (reg_write) begin
      case (int'(reg_addr))
        0: m_en[7:0]  = reg_wdata;
        1: m_en[15:8] = reg_wdata;
        2: clr[7:0]   = clr[7:0] | reg_wdata;
        3: clr[15:8]  = clr[15:8] | reg_wdata;
        4, 5, 6, 7: for (int j = 0; j < 4; j++)
          m_pr[(int'(reg_addr) - 4) * 4 + j] = int'(reg_wdata[2*j +: 2]);
        default: ;
      endcase
    end
    m_pend  = (irq_src & ~m_prev) | (m_pend & ~clr);
    m_prev  = irq_src;
    m_npend = (nmi_in && !m_nprev) || (m_npend && !nclr);
    m_nprev = nmi_in;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("m_level", 32'(cpu_irq_level), 32'(m_lvl));
    chk("m_vector", 32'(cpu_vector), 32'(m_vec));
    chk("m_rdata", 32'(reg_rdata), 32'(m_rdata));
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    reg_write = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic rd(string tag, logic [3:0] a, logic [7:0] exp);
    reg_read = 1'b1; reg_addr = a;
    tick();
    reg_read = 1'b0;
    chk(tag, 32'(reg_rdata), 32'(exp));
  endtask

  task automatic ack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = 16'hFFFF; iack = 1'b0; nmi_in = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_write = 1'b0; reg_read = 1'b0;
    tick(); tick();
    chk("rst_level", 32'(cpu_irq_level), 32'd0);
    chk("rst_vector", 32'(cpu_vector), 32'h00);
    chk("rst_rdata", 32'(reg_rdata), 32'h00);

    // Source held high through reset release must not latch
    reset = 1'b0;
    tick(); tick();
    rd("held_pend_lo", 4'h2, 8'h00);
    rd("held_pend_hi", 4'h3, 8'h00);
    rd("unmapped_c", 4'hC, 8'h00);
    irq_src = 16'h0000;
    tick();

    // Single source, two-edge latency, acknowledge and STATUS busy window
    wr(4'h0, 8'h01); wr(4'h4, 8'h02);
    irq_src = 16'h0001;
    tick();
    chk("lat_edge1", 32'(cpu_irq_level), 32'd0);
    tick();
    chk("s0_level", 32'(cpu_irq_level), 32'd2);
    chk("s0_vector", 32'(cpu_vector), 32'h10);
    ack();
    chk("s0_ack_level", 32'(cpu_irq_level), 32'd0);
    rd("s0_status_busy", 4'h8, 8'h80);
    rd("s0_pend_clr", 4'h2, 8'h00);
    rd("s0_status_idle", 4'h8, 8'h00);
    irq_src = 16'h0000;

    // Equal-priority tie goes to lower index, then the other re-requests
    wr(4'h0, 8'h28); wr(4'h4, 8'h40); wr(4'h5, 8'h04);
    irq_src = 16'h0028;
    tick(); tick();
    chk("tie_vector", 32'(cpu_vector), 32'h16);
    chk("tie_level", 32'(cpu_irq_level), 32'd1);
    ack(); tick(); tick();
    chk("tie_next_vector", 32'(cpu_vector), 32'h1A);
    ack(); tick(); tick();
    chk("tie_drained", 32'(cpu_irq_level), 32'd0);
    irq_src = 16'h0000;

    // Higher-priority arrival preempts before acknowledge
    wr(4'h0, 8'h04); wr(4'h1, 8'h02); wr(4'h4, 8'h10); wr(4'h6, 8'h0C);
    irq_src = 16'h0004;
    tick(); tick();
    chk("pre_low_vector", 32'(cpu_vector), 32'h14);
    irq_src = 16'h0204;
    tick(); tick();
    chk("pre_level", 32'(cpu_irq_level), 32'd3);
    chk("pre_vector", 32'(cpu_vector), 32'h22);
    ack();
    rd("pre_pend_hi", 4'h3, 8'h00);
    rd("pre_pend_lo", 4'h2, 8'h04);
    chk("pre_resume", 32'(cpu_vector), 32'h14);

    // Software clear of the sole presented source withdraws the request
    wr(4'h2, 8'h04);
    tick();
    chk("w1c_idle", 32'(cpu_irq_level), 32'd0);
    irq_src = 16'h0200; tick();
    irq_src = 16'h0204; tick();
    irq_src = 16'h0200; tick();
    reg_write = 1'b1; reg_addr = 4'h2; reg_wdata = 8'h04; irq_src = 16'h0204;
    tick();
    reg_write = 1'b0;
    rd("w1c_set_wins", 4'h2, 8'h04);
    chk("w1c_still_req", 32'(cpu_irq_level), 32'd1);

    // Reset while a request is shown
    reset = 1'b1;
    tick();
    chk("mid_rst_level", 32'(cpu_irq_level), 32'd0);
    chk("mid_rst_vector", 32'(cpu_vector), 32'h00);
    reset = 1'b0; irq_src = 16'h0000;
    tick();

`ifdef IRQ_CONTROLLER_NMI_EN
    wr(4'h0, 8'h02); wr(4'h4, 8'h0C);
    irq_src = 16'h0002;
    tick(); tick();
    chk("nmi_src1_vector", 32'(cpu_vector), 32'h12);
    nmi_in = 1'b1;
    tick(); tick();
    chk("nmi_level", 32'(cpu_irq_level), 32'd3);
    chk("nmi_vector", 32'(cpu_vector), 32'h04);
    ack();
    rd("nmi_status", 4'h8, 8'h8F);
    tick();
    chk("nmi_resume", 32'(cpu_vector), 32'h12);
    nmi_in = 1'b0; reset = 1'b1; irq_src = 16'h0000;
    tick();
    reset = 1'b0;
`endif

    // Random traffic against the model
    wr(4'h0, 8'hFF); wr(4'h1, 8'hFF);
    for (int k = 4; k < 8; k++) wr(4'(k), 8'($urandom));
    for (int c = 0; c < 1500; c++) begin
      irq_src   = irq_src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      iack      = ($urandom_range(0, 3) == 0);
      reg_write = ($urandom_range(0, 7) == 0);
      reg_read  = ($urandom_range(0, 1) == 0);
      reg_addr  = 4'($urandom);
      reg_wdata = 8'($urandom);
      reset     = ($urandom_range(0, 399) == 0);
`ifdef IRQ_CONTROLLER_NMI_EN
      nmi_in    = nmi_in ^ ($urandom_range(0, 30) == 0);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
